// File: rtl/ipg_blk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ipg_blk_pkg
//  Description : Shared definitions for the IPG read-request path:
//                block-type codes, header field geometry, parser and
//                generator state encodings, and the job record width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ipg_blk_pkg;

    // Block types carried in bits [7:0] of every IPG block
    localparam logic [7:0] c_BT_READFIRST = 8'h0a;
    localparam logic [7:0] c_BT_READ      = 8'h1a;
    localparam logic [7:0] c_BT_READLAST  = 8'h2a;
    localparam logic [7:0] c_BT_RESPFIRST = 8'h0b;
    localparam logic [7:0] c_BT_RRESP     = 8'h1b;
    localparam logic [7:0] c_BT_RESPLAST  = 8'h2b;

    // Width of the block-type field
    localparam int c_BT_W      = 8;
    // Reserved bits between the length field and the src_port field
    localparam int c_HDR_GAP_W = 8;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_ADDR = 2'd1,
        P_DST  = 2'd2
    } parse_state_t;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_HDR  = 2'd1,
        G_DATA = 2'd2
    } gen_state_t;

    // Job record: {len, src_port, dst_port, src_addr, dst_addr}
    function automatic int job_width(input int len_w, input int port_w, input int addr_w);
        return len_w + 2 * port_w + 2 * addr_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ipg_job_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ipg_job_fifo
//  Description : Synchronous job FIFO, depth 2**DEPTH_LOG2, with show-ahead
//                read data. A write into a full FIFO is accepted only when a
//                read happens in the same cycle.
//  Ports       : clk, reset      - clock, synchronous active-high reset
//                i_wr_en/i_wr_data - write request and data
//                i_rd_en         - read request (ignored when empty)
//                o_rd_data       - head entry (valid when !o_empty)
//                o_full/o_empty/o_count - occupancy status
//  Revision    : 1.0 - initial release
// ============================================================================
module ipg_job_fifo #(
    parameter int WIDTH      = 132,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_count
);

    localparam int                c_DEPTH_N = 2 ** DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      r_mem [0:c_DEPTH_N-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;

    logic w_rd_ok;
    logic w_wr_ok;

    assign o_full    = (r_count == c_DEPTH);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rd_data = r_mem[r_rd_ptr];

    assign w_rd_ok = i_rd_en && !o_empty;
    // The slot freed by a same-cycle read makes room for the write
    assign w_wr_ok = i_wr_en && (!o_full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + DEPTH_LOG2'(1);
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + DEPTH_LOG2'(1);
            end
            case ({w_wr_ok, w_rd_ok})
                2'b10:   r_count <= r_count + (DEPTH_LOG2 + 1)'(1);
                2'b01:   r_count <= r_count - (DEPTH_LOG2 + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/ipg_rreq_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ipg_rreq_engine
//  Description : IPG read-request processor. Parses FIRST/MID/LAST read
//                request blocks into jobs, queues them, and emits one
//                response burst per job (header + ceil(len/7) data chunks)
//                over a valid/ready interface.
//  Ports       : clk, reset        - clock, synchronous active-high reset
//                rx_valid, rx_data - received IPG block
//                out_valid, out_ready, out_chunk - response chunk handshake
//                job_full, job_count - job FIFO status
//                err_count         - protocol errors (saturating)
//                drop_count        - requests lost to a full FIFO (saturating)
//  Revision    : 1.0 - initial release
// ============================================================================
module ipg_rreq_engine
    import ipg_blk_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int LEN_WIDTH      = 8,
    parameter int PORT_WIDTH     = 6,
    parameter int JOB_DEPTH_LOG2 = 3,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      rx_valid,
    input  logic [DATA_WIDTH-1:0]     rx_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WIDTH-1:0]     out_chunk,
    output logic                      job_full,
    output logic [JOB_DEPTH_LOG2:0]   job_count,
    output logic [CNT_WIDTH-1:0]      err_count,
    output logic [CNT_WIDTH-1:0]      drop_count
);

    localparam int c_ADDR_W = DATA_WIDTH - c_BT_W;
    localparam int c_SRC_HI = DATA_WIDTH - 1 - LEN_WIDTH - c_HDR_GAP_W;
    localparam int c_DST_HI = c_SRC_HI - PORT_WIDTH;
    localparam int c_JOB_W  = job_width(LEN_WIDTH, PORT_WIDTH, c_ADDR_W);

    // ------------------------------------------------------------------
    // Receive block fields
    // ------------------------------------------------------------------
    logic [7:0]            w_rx_type;
    logic [c_ADDR_W-1:0]   w_rx_payload;
    logic [LEN_WIDTH-1:0]  w_rx_len;
    logic [PORT_WIDTH-1:0] w_rx_src;
    logic [PORT_WIDTH-1:0] w_rx_dst;

    assign w_rx_type    = rx_data[7:0];
    assign w_rx_payload = rx_data[DATA_WIDTH-1:c_BT_W];
    assign w_rx_len     = rx_data[DATA_WIDTH-1 -: LEN_WIDTH];
    assign w_rx_src     = rx_data[c_SRC_HI -: PORT_WIDTH];
    assign w_rx_dst     = rx_data[c_DST_HI -: PORT_WIDTH];

    // ------------------------------------------------------------------
    // Parser FSM
    // ------------------------------------------------------------------
    parse_state_t          r_p_state;
    parse_state_t          w_p_next;
    logic                  w_hdr_load;
    logic                  w_saddr_load;
    logic                  w_push;
    logic                  w_err;

    logic [LEN_WIDTH-1:0]  r_hdr_len;
    logic [PORT_WIDTH-1:0] r_hdr_src;
    logic [PORT_WIDTH-1:0] r_hdr_dst;
    logic [c_ADDR_W-1:0]   r_saddr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_p_state <= P_IDLE;
        end else begin
            r_p_state <= w_p_next;
        end
    end

    always_comb begin
        w_p_next     = r_p_state;
        w_hdr_load   = 1'b0;
        w_saddr_load = 1'b0;
        w_push       = 1'b0;
        w_err        = 1'b0;
        if (rx_valid) begin
            case (r_p_state)
                P_IDLE: begin
                    // Stray non-header blocks are silently ignored here
                    if (w_rx_type == c_BT_READFIRST) begin
                        w_hdr_load = 1'b1;
                        w_p_next   = P_ADDR;
                    end
                end
                P_ADDR: begin
                    if (w_rx_type == c_BT_READ) begin
                        w_saddr_load = 1'b1;
                        w_p_next     = P_DST;
                    end else if (w_rx_type == c_BT_READFIRST) begin
                        w_hdr_load = 1'b1;
                        w_err      = 1'b1;
                    end else begin
                        w_err    = 1'b1;
                        w_p_next = P_IDLE;
                    end
                end
                P_DST: begin
                    if (w_rx_type == c_BT_READLAST) begin
                        w_push   = 1'b1;
                        w_p_next = P_IDLE;
                    end else if (w_rx_type == c_BT_READFIRST) begin
                        w_hdr_load = 1'b1;
                        w_err      = 1'b1;
                        w_p_next   = P_ADDR;
                    end else begin
                        w_err    = 1'b1;
                        w_p_next = P_IDLE;
                    end
                end
                default: w_p_next = P_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hdr_len <= '0;
            r_hdr_src <= '0;
            r_hdr_dst <= '0;
            r_saddr   <= '0;
        end else begin
            if (w_hdr_load) begin
                r_hdr_len <= w_rx_len;
                r_hdr_src <= w_rx_src;
                r_hdr_dst <= w_rx_dst;
            end
            if (w_saddr_load) begin
                r_saddr <= w_rx_payload;
            end
        end
    end

    // ------------------------------------------------------------------
    // Job FIFO
    // ------------------------------------------------------------------
    logic [c_JOB_W-1:0]    w_wr_job;
    logic [c_JOB_W-1:0]    w_rd_job;
    logic                  w_pop;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;
    logic                  w_drop;

    // The READLAST payload goes straight into the job without a register
    assign w_wr_job = {r_hdr_len, r_hdr_src, r_hdr_dst, r_saddr, w_rx_payload};

    ipg_job_fifo #(
        .WIDTH      (c_JOB_W),
        .DEPTH_LOG2 (JOB_DEPTH_LOG2)
    ) u_job_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_push),
        .i_wr_data (w_wr_job),
        .i_rd_en   (w_pop),
        .o_rd_data (w_rd_job),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty),
        .o_count   (job_count)
    );

    assign job_full = w_fifo_full;
    assign w_drop   = w_push && w_fifo_full && !w_pop;

    logic [LEN_WIDTH-1:0]  w_rd_len;
    logic [PORT_WIDTH-1:0] w_rd_src;
    logic [PORT_WIDTH-1:0] w_rd_dst;
    logic [c_ADDR_W-1:0]   w_rd_saddr;
    logic [c_ADDR_W-1:0]   w_unused_daddr;
    logic [LEN_WIDTH:0]    w_len_plus6;
    logic [LEN_WIDTH-1:0]  w_n_calc;

    assign w_rd_len       = w_rd_job[c_JOB_W-1 -: LEN_WIDTH];
    assign w_rd_src       = w_rd_job[c_JOB_W-1-LEN_WIDTH -: PORT_WIDTH];
    assign w_rd_dst       = w_rd_job[c_JOB_W-1-LEN_WIDTH-PORT_WIDTH -: PORT_WIDTH];
    assign w_rd_saddr     = w_rd_job[2*c_ADDR_W-1 -: c_ADDR_W];
    // Destination address is carried for the memory side; the reply does not use it
    assign w_unused_daddr = w_rd_job[c_ADDR_W-1:0];

    // ceil(len/7): seven payload bytes per data chunk
    assign w_len_plus6 = {1'b0, w_rd_len} + (LEN_WIDTH + 1)'(6);
    assign w_n_calc    = LEN_WIDTH'(w_len_plus6 / (LEN_WIDTH + 1)'(7));

    // ------------------------------------------------------------------
    // Response generator FSM
    // ------------------------------------------------------------------
    gen_state_t            r_g_state;
    gen_state_t            w_g_next;
    logic                  w_idx_inc;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_resp_hdr;

    logic [LEN_WIDTH-1:0]  r_job_len;
    logic [PORT_WIDTH-1:0] r_job_src;
    logic [PORT_WIDTH-1:0] r_job_dst;
    logic [c_ADDR_W-1:0]   r_job_saddr;
    logic [LEN_WIDTH-1:0]  r_n;
    logic [LEN_WIDTH-1:0]  r_idx;

    assign w_last = (r_idx == r_n - LEN_WIDTH'(1));

    // Reply header reuses the request layout with the ports swapped
    always_comb begin
        w_resp_hdr                              = '0;
        w_resp_hdr[DATA_WIDTH-1 -: LEN_WIDTH]   = r_job_len;
        w_resp_hdr[c_SRC_HI -: PORT_WIDTH]      = r_job_dst;
        w_resp_hdr[c_DST_HI -: PORT_WIDTH]      = r_job_src;
        w_resp_hdr[7:0]                         = c_BT_RESPFIRST;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_g_state <= G_IDLE;
        end else begin
            r_g_state <= w_g_next;
        end
    end

    always_comb begin
        w_g_next  = r_g_state;
        w_pop     = 1'b0;
        w_idx_inc = 1'b0;
        out_valid = 1'b0;
        out_chunk = '0;
        case (r_g_state)
            G_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop    = 1'b1;
                    w_g_next = G_HDR;
                end
            end
            G_HDR: begin
                out_valid = 1'b1;
                out_chunk = w_resp_hdr;
                if (out_ready) begin
                    w_g_next = (r_n == '0) ? G_IDLE : G_DATA;
                end
            end
            G_DATA: begin
                out_valid = 1'b1;
                out_chunk = {r_job_saddr + c_ADDR_W'(r_idx),
                             w_last ? c_BT_RESPLAST : c_BT_RRESP};
                if (out_ready) begin
                    w_idx_inc = 1'b1;
                    if (w_last) begin
                        w_g_next = G_IDLE;
                    end
                end
            end
            default: w_g_next = G_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_job_len   <= '0;
            r_job_src   <= '0;
            r_job_dst   <= '0;
            r_job_saddr <= '0;
            r_n         <= '0;
            r_idx       <= '0;
        end else if (w_pop) begin
            r_job_len   <= w_rd_len;
            r_job_src   <= w_rd_src;
            r_job_dst   <= w_rd_dst;
            r_job_saddr <= w_rd_saddr;
            r_n         <= w_n_calc;
            r_idx       <= '0;
        end else if (w_idx_inc) begin
            r_idx <= r_idx + LEN_WIDTH'(1);
        end
    end

    // ------------------------------------------------------------------
    // Saturating counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count  <= '0;
            drop_count <= '0;
        end else begin
            if (w_err && (err_count != '1)) begin
                err_count <= err_count + CNT_WIDTH'(1);
            end
            if (w_drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ipg_rreq_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ipg_rreq_engine
//  Description : Directed self-checking bench for ipg_rreq_engine. Accepted
//                response chunks are collected at the falling edge and
//                compared against hand-written values and against bursts
//                expanded from the request parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ipg_rreq_engine;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic [63:0] rx_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_chunk;
    logic        job_full;
    logic [3:0]  job_count;
    logic [15:0] err_count;
    logic [15:0] drop_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] q_out[$];
    logic [63:0] q_exp[$];

    ipg_rreq_engine dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_chunk  (out_chunk),
        .job_full   (job_full),
        .job_count  (job_count),
        .err_count  (err_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Handshakes complete on the following rising edge; inputs change only at +1
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            q_out.push_back(out_chunk);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_blk(input logic [63:0] d);
        rx_valid = 1'b1;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = '0;
    endtask

    function automatic logic [63:0] mk_req_hdr(input logic [7:0] len, input logic [5:0] src,
                                               input logic [5:0] dst);
        return {len, 8'h00, src, dst, 28'h0, 8'h0a};
    endfunction

    task automatic send_req(input logic [7:0] len, input logic [5:0] src, input logic [5:0] dst,
                            input logic [55:0] sa, input logic [55:0] da);
        send_blk(mk_req_hdr(len, src, dst));
        send_blk({sa, 8'h1a});
        send_blk({da, 8'h2a});
    endtask

    // Expected reply: header with ports swapped, then ceil(len/7) data chunks
    task automatic exp_burst(input logic [7:0] len, input logic [5:0] src, input logic [5:0] dst,
                             input logic [55:0] sa);
        int n;
        n = (int'(len) + 6) / 7;
        q_exp.push_back({len, 8'h00, dst, src, 28'h0, 8'h0b});
        for (int i = 0; i < n; i++) begin
            q_exp.push_back({sa + 56'(i), (i == n - 1) ? 8'h2b : 8'h1b});
        end
    endtask

    task automatic cmp_queues(input string tag);
        chk({tag, "_nchunks"}, 64'(q_out.size()), 64'(q_exp.size()));
        for (int i = 0; i < q_out.size() && i < q_exp.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), q_out[i], q_exp[i]);
        end
        q_out.delete();
        q_exp.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        rx_valid  = 1'b0;
        rx_data   = '0;
        out_ready = 1'b1;
        run_cycles(3);

        // Reset state
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_chunk", out_chunk, 64'd0);
        chk("rst_job_full", 64'(job_full), 64'd0);
        chk("rst_job_count", 64'(job_count), 64'd0);
        chk("rst_err", 64'(err_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);
        reset = 1'b0;
        run_cycles(2);

        // Basic request, len=14, src=0, dst=2
        send_req(8'd14, 6'd0, 6'd2, 56'h34567890ABCD12, 56'h11);
        chk("t1_count_after_push", 64'(job_count), 64'd1);
        chk("t1_valid_after_push", 64'(out_valid), 64'd0);
        run_cycles(1);
        chk("t1_valid_hdr", 64'(out_valid), 64'd1);
        chk("t1_hdr_live", out_chunk, 64'h0E00_0800_0000_000B);
        chk("t1_count_after_pop", 64'(job_count), 64'd0);
        run_cycles(8);
        chk("t1_nchunks", 64'(q_out.size()), 64'd3);
        if (q_out.size() == 3) begin
            chk("t1_hdr", q_out[0], 64'h0E00_0800_0000_000B);
            chk("t1_d0", q_out[1], 64'h3456_7890_ABCD_121B);
            chk("t1_d1", q_out[2], 64'h3456_7890_ABCD_132B);
        end
        chk("t1_err", 64'(err_count), 64'd0);
        chk("t1_drop", 64'(drop_count), 64'd0);
        q_out.delete();

        // len=0: header only, idle right after its handshake
        send_req(8'd0, 6'd5, 6'd9, 56'h77, 56'h88);
        run_cycles(1);
        chk("t2_valid", 64'(out_valid), 64'd1);
        chk("t2_hdr", out_chunk, 64'h0000_2450_0000_000B);
        run_cycles(1);
        chk("t2_idle_after", 64'(out_valid), 64'd0);
        run_cycles(4);
        chk("t2_nchunks", 64'(q_out.size()), 64'd1);
        q_out.delete();

        // Repeated header: error, second header wins
        send_blk(mk_req_hdr(8'd7, 6'd1, 6'd3));
        send_blk(mk_req_hdr(8'd14, 6'd4, 6'd6));
        send_blk({56'h100, 8'h1a});
        send_blk({56'h200, 8'h2a});
        run_cycles(8);
        chk("t3_err", 64'(err_count), 64'd1);
        chk("t3_nchunks", 64'(q_out.size()), 64'd3);
        if (q_out.size() == 3) begin
            chk("t3_hdr", q_out[0], 64'h0E00_1840_0000_000B);
            chk("t3_d0", q_out[1], 64'h0000_0000_0001_001B);
            chk("t3_d1", q_out[2], 64'h0000_0000_0001_012B);
        end
        q_out.delete();

        // Wrong block type in P_ADDR: error, no job
        send_blk(mk_req_hdr(8'd7, 6'd1, 6'd3));
        send_blk({56'h5, 8'h1b});
        run_cycles(6);
        chk("t4_err", 64'(err_count), 64'd2);
        chk("t4_nchunks", 64'(q_out.size()), 64'd0);
        chk("t4_count", 64'(job_count), 64'd0);
        q_out.delete();

        // Stalled output: one job in the generator, 8 queued, one dropped
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_req(8'd7, 6'(i), 6'(63 - i), 56'h10_0000_0000_0000 + 56'(i) * 56'h100, 56'h0);
            if (i < 9) exp_burst(8'd7, 6'(i), 6'(63 - i), 56'h10_0000_0000_0000 + 56'(i) * 56'h100);
            if (i == 4) begin
                chk("t5_stall_hdr_mid", out_chunk, 64'h0700_FC00_0000_000B);
            end
        end
        run_cycles(2);
        chk("t5_full", 64'(job_full), 64'd1);
        chk("t5_count", 64'(job_count), 64'd8);
        chk("t5_drop", 64'(drop_count), 64'd1);
        chk("t5_stall_valid", 64'(out_valid), 64'd1);
        chk("t5_stall_hdr_end", out_chunk, 64'h0700_FC00_0000_000B);
        chk("t5_no_hs_stalled", 64'(q_out.size()), 64'd0);
        out_ready = 1'b1;
        run_cycles(40);
        cmp_queues("t5");
        chk("t5_count_end", 64'(job_count), 64'd0);
        chk("t5_full_end", 64'(job_full), 64'd0);

        // Address wrap at 2**56
        send_req(8'd14, 6'd1, 6'd2, 56'hFF_FFFF_FFFF_FFFF, 56'h0);
        run_cycles(8);
        chk("t6_nchunks", 64'(q_out.size()), 64'd3);
        if (q_out.size() == 3) begin
            chk("t6_d0", q_out[1], 64'hFFFF_FFFF_FFFF_FF1B);
            chk("t6_d1", q_out[2], 64'h0000_0000_0000_002B);
        end
        q_out.delete();

        // Maximum length: 37 data chunks
        send_req(8'd255, 6'd3, 6'd4, 56'h10, 56'h0);
        exp_burst(8'd255, 6'd3, 6'd4, 56'h10);
        run_cycles(50);
        chk("t7_nchunks", 64'(q_out.size()), 64'd38);
        if (q_out.size() == 38) begin
            chk("t7_last", q_out[37], 64'h0000_0000_0000_342B);
        end
        cmp_queues("t7");

        // Reset in the middle of a len=56 burst
        send_req(8'd56, 6'd2, 6'd3, 56'h400, 56'h0);
        run_cycles(4);
        chk("t8_in_data", out_chunk, 64'h0000_0000_0004_021B);
        reset = 1'b1;
        run_cycles(1);
        chk("t8_valid", 64'(out_valid), 64'd0);
        chk("t8_chunk", out_chunk, 64'd0);
        chk("t8_count", 64'(job_count), 64'd0);
        chk("t8_err", 64'(err_count), 64'd0);
        chk("t8_drop", 64'(drop_count), 64'd0);
        reset = 1'b0;
        q_out.delete();
        run_cycles(12);
        chk("t8_no_partial", 64'(q_out.size()), 64'd0);
        q_out.delete();

        send_req(8'd21, 6'd7, 6'd8, 56'hABC, 56'h0);
        exp_burst(8'd21, 6'd7, 6'd8, 56'hABC);
        run_cycles(10);
        cmp_queues("t8_fresh");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
